// File: rtl/qspi_pkg.sv
// Shared types and derived constants for the QSPI nibble front end.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_HDR,
    RX_ADDR,
    RX_DATA,
    TURN,
    TX
  } state_e;

  function automatic int npw(input int dw);
    return dw / 4;
  endfunction

  function automatic int read_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/qspi_nibble_phy_if.sv
// Pin-side bus and word-side stream signals of the QSPI nibble PHY.
interface qspi_nibble_phy_if #(
  parameter int DW = 16
);

  logic          qspi_cs_n;
  logic [3:0]    qspi_io_in;
  logic [3:0]    qspi_io_out;
  logic          qspi_io_oe;
  logic [DW-1:0] mosi;
  logic          mosi_valid;
  logic [DW-1:0] miso;
  logic          miso_valid;
  logic          tx_underflow;
  logic          tx_overflow;
  logic          frame_active;

  modport master (
    output qspi_cs_n, qspi_io_in, miso, miso_valid,
    input  qspi_io_out, qspi_io_oe, mosi, mosi_valid,
    input  tx_underflow, tx_overflow, frame_active
  );

  modport slave (
    input  qspi_cs_n, qspi_io_in, miso, miso_valid,
    output qspi_io_out, qspi_io_oe, mosi, mosi_valid,
    output tx_underflow, tx_overflow, frame_active
  );

endinterface

// File: rtl/qspi_txq.sv
// Return-word FIFO; an empty queue forwards a same-cycle push straight to the pop.
module qspi_txq
  import qspi_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          bypass, do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign bypass     = empty_o && push_i && pop_i;
  assign do_pop     = pop_i && !empty_o && !flush_i;
  assign do_push    = push_i && (!full_o || pop_i) && !bypass && !flush_i;
  assign pop_data_o = !empty_o ? mem_q[rd_q] : (push_i ? push_data_i : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/qspi_nibble_phy.sv
// QSPI pin front end: nibble deserializer, read-frame turnaround and nibble serializer.
module qspi_nibble_phy
  import qspi_pkg::*;
#(
  parameter int DW           = 16,
  parameter int ADDR_WORDS   = 2,
  parameter int DUMMY_CYCLES = 4,
  parameter int TXQ_AW       = 2
) (
  input logic              clk,
  input logic              rst,
  qspi_nibble_phy_if.slave bus
);

  localparam int NPW      = npw(DW);
  localparam int READ_BIT = read_bit(DW);
  localparam int NCW      = (NPW > 1) ? $clog2(NPW) : 1;
  localparam int ACW      = $clog2(ADDR_WORDS + 1);
  localparam int TCW      = $clog2(DUMMY_CYCLES + 1);

  state_e         state_q, state_d;
  logic [DW-5:0]  rx_sr_q, rx_sr_d;
  logic [NCW-1:0] nib_q, nib_d, txnib_q, txnib_d;
  logic [ACW-1:0] addr_q, addr_d;
  logic [TCW-1:0] turn_q, turn_d;
  logic [DW-1:0]  tx_sr_q, tx_sr_d, mosi_q, mosi_d;
  logic [3:0]     io_out_q, io_out_d;
  logic           is_read_q, is_read_d, mosi_valid_q, mosi_valid_d;
  logic           io_oe_q, io_oe_d, under_q, under_d, over_q, over_d;

  logic [DW-1:0]  rx_word, q_data;
  logic           abort, q_push, q_pop, q_full, q_empty, q_overflow;

  assign rx_word    = {rx_sr_q, bus.qspi_io_in};
  assign abort      = bus.qspi_cs_n && (state_q != IDLE);
  assign q_push     = bus.miso_valid && (state_q != IDLE);
  assign q_pop      = !abort &&
                      (((state_q == TURN) && (turn_q == TCW'(DUMMY_CYCLES - 1))) ||
                       ((state_q == TX)   && (txnib_q == NCW'(NPW - 1))));
  assign q_overflow = q_push && q_full && !q_pop && !abort;

  qspi_txq #(.DW(DW), .AW(TXQ_AW)) u_txq (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (abort),
    .push_i     (q_push),
    .push_data_i(bus.miso),
    .pop_i      (q_pop),
    .pop_data_o (q_data),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  always_comb begin
    state_d      = state_q;
    rx_sr_d      = rx_sr_q;
    nib_d        = nib_q;
    addr_d       = addr_q;
    turn_d       = turn_q;
    tx_sr_d      = tx_sr_q;
    txnib_d      = txnib_q;
    is_read_d    = is_read_q;
    mosi_d       = mosi_q;
    mosi_valid_d = 1'b0;
    io_out_d     = io_out_q;
    io_oe_d      = io_oe_q;
    under_d      = under_q;
    over_d       = over_q | q_overflow;

    // A pop both starts the next word on the pins and refills the shift register.
    if (q_pop) begin
      io_out_d = q_data[DW-1 -: 4];
      tx_sr_d  = q_data << 4;
      txnib_d  = '0;
      io_oe_d  = 1'b1;
      if (q_empty && !q_push) under_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (!bus.qspi_cs_n) begin
          rx_sr_d   = rx_word[DW-5:0];
          nib_d     = NCW'(1);
          addr_d    = '0;
          turn_d    = '0;
          is_read_d = bus.qspi_io_in[READ_BIT - (DW - 4)];
          under_d   = 1'b0;
          over_d    = 1'b0;
          state_d   = RX_HDR;
        end
      end
      RX_HDR, RX_ADDR, RX_DATA: begin
        rx_sr_d = rx_word[DW-5:0];
        if (nib_q == NCW'(NPW - 1)) begin
          nib_d        = '0;
          mosi_d       = rx_word;
          mosi_valid_d = 1'b1;
          if (state_q == RX_HDR) begin
            state_d = is_read_q ? RX_ADDR : RX_DATA;
          end else if (state_q == RX_ADDR) begin
            if (addr_q == ACW'(ADDR_WORDS - 1)) state_d = TURN;
            else                                addr_d  = addr_q + 1'b1;
          end
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      TURN: begin
        if (q_pop) state_d = TX;
        else       turn_d  = turn_q + 1'b1;
      end
      TX: begin
        if (!q_pop) begin
          io_out_d = tx_sr_q[DW-1 -: 4];
          tx_sr_d  = tx_sr_q << 4;
          txnib_d  = txnib_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Deselect mid-frame drops any partial word and releases the bus at once.
    if (abort) begin
      state_d      = IDLE;
      nib_d        = '0;
      mosi_d       = mosi_q;
      mosi_valid_d = 1'b0;
      io_oe_d      = 1'b0;
      io_out_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_sr_q      <= '0;
      nib_q        <= '0;
      addr_q       <= '0;
      turn_q       <= '0;
      tx_sr_q      <= '0;
      txnib_q      <= '0;
      is_read_q    <= 1'b0;
      mosi_q       <= '0;
      mosi_valid_q <= 1'b0;
      io_out_q     <= '0;
      io_oe_q      <= 1'b0;
      under_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_sr_q      <= rx_sr_d;
      nib_q        <= nib_d;
      addr_q       <= addr_d;
      turn_q       <= turn_d;
      tx_sr_q      <= tx_sr_d;
      txnib_q      <= txnib_d;
      is_read_q    <= is_read_d;
      mosi_q       <= mosi_d;
      mosi_valid_q <= mosi_valid_d;
      io_out_q     <= io_out_d;
      io_oe_q      <= io_oe_d;
      under_q      <= under_d;
      over_q       <= over_d;
    end
  end

  assign bus.qspi_io_out  = io_out_q;
  assign bus.qspi_io_oe   = io_oe_q;
  assign bus.mosi         = mosi_q;
  assign bus.mosi_valid   = mosi_valid_q;
  assign bus.tx_underflow = under_q;
  assign bus.tx_overflow  = over_q;
  assign bus.frame_active = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_nibble_phy.sv
// Directed-sequence bench with random payloads, checked against a word-level model of the PHY.
module tb_qspi_nibble_phy;
  import qspi_pkg::*;

  localparam int DW           = 16;
  localparam int ADDR_WORDS   = 2;
  localparam int DUMMY_CYCLES = 4;
  localparam int TXQ_AW       = 2;
  localparam int NPW          = DW / 4;
  localparam int QDEPTH       = 1 << TXQ_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] txModel[$];
  bit            expUnder;
  bit            expOver;

  qspi_nibble_phy_if #(.DW(DW)) bus ();

  qspi_nibble_phy #(
    .DW(DW), .ADDR_WORDS(ADDR_WORDS), .DUMMY_CYCLES(DUMMY_CYCLES), .TXQ_AW(TXQ_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle and return 1 time unit after its rising edge.
  task automatic applyStimulus(input logic csn, input logic [3:0] io,
                               input logic mv, input logic [DW-1:0] md);
    bus.qspi_cs_n  = csn;
    bus.qspi_io_in = io;
    bus.miso_valid = mv;
    bus.miso       = md;
    @(posedge clk);
    #1;
  endtask

  task automatic modelPush(input logic [DW-1:0] w);
    if (txModel.size() < QDEPTH) txModel.push_back(w);
    else                         expOver = 1'b1;
  endtask

  task automatic sendWord(input logic [DW-1:0] w, input int nPush);
    logic [DW-1:0] md;
    for (int k = 0; k < NPW; k++) begin
      md = DW'($urandom);
      if (k < nPush) modelPush(md);
      applyStimulus(1'b0, w[DW-1-4*k -: 4], k < nPush, md);
      checkOutput("rx_valid", bus.mosi_valid, (k == NPW-1));
      checkOutput("rx_oe", bus.qspi_io_oe, 0);
      if (k == NPW-1) checkOutput("rx_word", bus.mosi, w);
    end
  endtask

  task automatic endFrame();
    applyStimulus(1'b1, 4'($urandom), 1'b0, '0);
    checkOutput("end_active", bus.frame_active, 0);
    checkOutput("end_oe", bus.qspi_io_oe, 0);
    checkOutput("end_valid", bus.mosi_valid, 0);
    txModel.delete();
  endtask

  task automatic writeFrame(input int nWords);
    sendWord({1'b0, 15'($urandom)}, 0);
    for (int i = 0; i < nWords; i++) sendWord(DW'($urandom), 0);
    endFrame();
  endtask

  // Header, address words (pushes spread over them) and the turnaround.
  task automatic readHead(input logic [DW-1:0] hdr, input logic [DW-1:0] a0,
                          input logic [DW-1:0] a1, input int nPush);
    expUnder = 1'b0;
    expOver  = 1'b0;
    txModel.delete();
    sendWord(hdr, 0);
    checkOutput("start_under_clr", bus.tx_underflow, 0);
    checkOutput("start_over_clr", bus.tx_overflow, 0);
    sendWord(a0, (nPush > NPW) ? NPW : nPush);
    sendWord(a1, (nPush > NPW) ? nPush - NPW : 0);
    checkOutput("turn_oe", bus.qspi_io_oe, 0);
    for (int t = 0; t < DUMMY_CYCLES-1; t++) begin
      applyStimulus(1'b0, 4'($urandom), 1'b0, '0);
      checkOutput("turn_oe", bus.qspi_io_oe, 0);
    end
  endtask

  task automatic txNibbles(input int nNib);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < nNib; j++) begin
      if (j % NPW == 0) begin
        if (txModel.size() > 0) w = txModel.pop_front();
        else begin
          w = '0;
          expUnder = 1'b1;
        end
      end
      applyStimulus(1'b0, 4'($urandom), 1'b0, '0);
      checkOutput("tx_oe", bus.qspi_io_oe, 1);
      checkOutput("tx_nibble", bus.qspi_io_out, w[DW-1-4*(j%NPW) -: 4]);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_under"}, bus.tx_underflow, expUnder);
    checkOutput({tag, "_over"}, bus.tx_overflow, expOver);
  endtask

  task automatic readFrame(input int nPush, input int nTxWords);
    readHead({1'b1, 15'($urandom)}, DW'($urandom), DW'($urandom), nPush);
    txNibbles(nTxWords * NPW);
    checkFlags("tx");
    endFrame();
    checkFlags("hold");
  endtask

  initial begin
    bus.qspi_cs_n  = 1'b1;
    bus.qspi_io_in = '0;
    bus.miso       = '0;
    bus.miso_valid = 1'b0;
    expUnder       = 1'b0;
    expOver        = 1'b0;

    applyStimulus(1'b1, 4'h0, 1'b0, '0);
    applyStimulus(1'b1, 4'h0, 1'b0, '0);
    checkOutput("rst_mosi", bus.mosi, 0);
    checkOutput("rst_valid", bus.mosi_valid, 0);
    checkOutput("rst_io_out", bus.qspi_io_out, 0);
    checkOutput("rst_oe", bus.qspi_io_oe, 0);
    checkOutput("rst_under", bus.tx_underflow, 0);
    checkOutput("rst_over", bus.tx_overflow, 0);
    checkOutput("rst_active", bus.frame_active, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'h0, 1'b0, '0);

    $display("[TB] directed write frame");
    sendWord(16'h1234, 0);
    sendWord(16'hABCD, 0);
    endFrame();
    writeFrame(4);

    $display("[TB] read frames");
    readHead(16'h8001, 16'h0003, 16'h0400, 1);
    txNibbles(NPW);
    checkFlags("read1");
    endFrame();
    readFrame(0, 1);
    readFrame(2, 3);
    readFrame(5, 4);
    readFrame(3, 2);

    $display("[TB] aborts");
    sendWord({1'b0, 15'($urandom)}, 0);
    applyStimulus(1'b0, 4'h5, 1'b0, '0);
    applyStimulus(1'b0, 4'h6, 1'b0, '0);
    applyStimulus(1'b1, 4'h7, 1'b0, '0);
    checkOutput("abort_valid", bus.mosi_valid, 0);
    checkOutput("abort_active", bus.frame_active, 0);
    applyStimulus(1'b0, 4'h1, 1'b0, '0);
    applyStimulus(1'b0, 4'h2, 1'b0, '0);
    applyStimulus(1'b0, 4'h3, 1'b0, '0);
    applyStimulus(1'b1, 4'h4, 1'b0, '0);
    checkOutput("abort_last_valid", bus.mosi_valid, 0);
    checkOutput("abort_last_active", bus.frame_active, 0);
    writeFrame(2);

    sendWord({1'b1, 15'($urandom)}, 0);
    sendWord(DW'($urandom), 3);
    endFrame();
    readFrame(0, 1);

    $display("[TB] async reset during TX");
    readHead({1'b1, 15'($urandom)}, DW'($urandom), DW'($urandom), 2);
    txNibbles(2);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_oe", bus.qspi_io_oe, 0);
    checkOutput("arst_active", bus.frame_active, 0);
    checkOutput("arst_io_out", bus.qspi_io_out, 0);
    checkOutput("arst_mosi", bus.mosi, 0);
    txModel.delete();
    applyStimulus(1'b1, 4'h0, 1'b0, '0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'h0, 1'b0, '0);
    readFrame(1, 1);
    writeFrame(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_nibble_phy.md
Name: qspi_nibble_phy

Overview:
- Pin-level front end of the QSPI path; sits directly upstream of the CDC/controller stage in the QSPI clock domain.
- Deserializes 4-bit QSPI nibbles into DW-bit words, presented as mosi/mosi_valid.
- Serializes returned DW-bit words (miso/miso_valid) back onto the bus during read frames.
- Decodes frame framing (chip select), read/write header, dummy turnaround, and IO direction.

Parameters:
- DW, 16, word width; must be a multiple of 4 (NPW = DW/4 nibbles per word).
- ADDR_WORDS, 2, words following the header before turnaround on a read frame.
- DUMMY_CYCLES, 4, turnaround cycles between the last address nibble and the first data-out nibble; must be ≥1.
- TXQ_AW, 2, log2 depth of the internal return-word queue.

Ports:
- clk  in  1  QSPI clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- qspi_cs_n  in  1  frame select, active low.
- qspi_io_in  in  4  sampled bus nibble, bit3 = MSB.
- qspi_io_out  out  4  driven nibble.
- qspi_io_oe  out  1  output enable for qspi_io_out.
- mosi  out  DW  received word.
- mosi_valid  out  1  one-cycle strobe per received word.
- miso  in  DW  return word.
- miso_valid  in  1  push strobe for miso.
- tx_underflow  out  1  sticky: a TX word was needed while the queue was empty.
- tx_overflow  out  1  sticky: miso_valid arrived while the queue was full.
- frame_active  out  1  high while state != IDLE.

Behaviour:
- Reset values: mosi=0, mosi_valid=0, qspi_io_out=0, qspi_io_oe=0, both sticky flags 0, frame_active=0. State=IDLE, counters 0, queue empty.
- States: IDLE, RX_HDR, RX_ADDR, RX_DATA, TURN, TX.
- IDLE: on a posedge with cs_n=0, sample io_in as nibble 0 of the header. Capture is_read = io_in[3]. Clear both sticky flags. Go to RX_HDR.
- Nibble shift: rx_sr <= {rx_sr[DW-5:0], io_in}; nib_cnt increments and wraps after NPW-1.
- Word emit: on the NPW-th nibble, mosi <= {rx_sr[DW-5:0], io_in} and mosi_valid=1 on the next cycle. Latency is 1 cycle after the last nibble edge.
- Header word: emitted like any other word.
  - is_read=0: go to RX_DATA.
  - is_read=1: go to RX_ADDR.
- RX_ADDR: after ADDR_WORDS words have been emitted, go to TURN. RX_DATA continues until cs_n rises.
- TURN: counts DUMMY_CYCLES cycles; io_in is ignored and io_oe=0.
  - On the last TURN cycle, pop the queue head into tx_sr; pop from an empty queue loads 0 and sets tx_underflow.
  - Then go to TX.
- TX: io_oe=1; qspi_io_out = tx_sr[DW-1:DW-4], registered, MSB nibble first.
  - Each cycle, shift tx_sr left by 4.
  - On the NPW-th nibble, reload from the queue, with the same underflow rule.
- Queue: TXQ depth 2^TXQ_AW, synchronous, written only when the state is not IDLE.
  - Push and pop in the same cycle are both honoured, including when full (pop frees a slot) or empty (push value bypasses to the pop).
  - Push when full and no pop: data dropped, tx_overflow set.
- cs_n=1 in any non-IDLE state: abort on that edge.
  - Partial rx nibbles are discarded; no mosi_valid is issued for a partial word.
  - io_oe=0; the queue is flushed; the state returns to IDLE the same cycle.
- cs_n=1 coinciding with the last nibble of a word: the word is NOT emitted.
- Reset mid-frame: immediate return to reset values.
- Sticky flags hold until the next frame start or reset.

Decomposition:
- Shared package (qspi_pkg): state enum, NPW derivation, header bit position READ_BIT = DW-1.
- One natural sub-module: qspi_txq, a small synchronous FIFO with bypass, full/empty and count.

Test Plan (DW=16, ADDR_WORDS=2, DUMMY_CYCLES=4):
- Write frame: cs_n low, nibbles 1,2,3,4 then A,B,C,D, cs_n high → mosi=0x1234 valid cycle 5, mosi=0xABCD valid cycle 9; io_oe never high.
- Read frame:
  - Stimulus: header 0x8001 and addr words 0x0003 and 0x0400; push miso 0xBEEF during RX_ADDR.
  - Response: three mosi strobes, then 4 turnaround cycles with io_oe=0.
  - Then io_out = B,E,E,F on 4 consecutive cycles with io_oe=1; tx_underflow=0.
- Underflow: same read frame with no miso push → io_out = 0,0,0,0 and tx_underflow=1.
  - tx_underflow clears at the next frame start.
- Overflow: push 5 words into the depth-4 queue before TX → tx_overflow=1.
  - The first 4 words are serialized in order; the 5th is never seen.
- Abort: cs_n rises after 2 nibbles of a word → no mosi_valid; state IDLE; the next frame's first word is assembled cleanly from nibble 0.
- Async reset mid-TX → io_oe=0 and frame_active=0 immediately, without waiting for a clock edge.
